// File: rtl/sram_access_sched.sv
// Round-robin two-port scheduler in front of the data_ram SRAM controller.
// Holds one command on write_en for ACC_CYCLES cycles, then a turnaround cycle.
//   state  | meaning
//   IDLE   | bus idle, arbitrating, ready may assert
//   ACCESS | command held on write_en, counter running
//   TURN   | bus turnaround, done pulse to the winner
module sram_access_sched #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int ACC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [1:0]        write_en,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

    localparam logic [1:0] WE_WR    = 2'b11;
    localparam logic [1:0] WE_RD    = 2'b00;
    localparam logic [1:0] WE_IDLE  = 2'b01;
    localparam logic [3:0] CNT_LAST = 4'(ACC_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last;
    logic       port;
    logic       gnt0, gnt1;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                // last==1 means port 1 won most recently, so a tie goes to port 0
                if (req0_valid && req1_valid) begin
                    gnt0 = last;
                    gnt1 = !last;
                end else begin
                    gnt0 = req0_valid;
                    gnt1 = req1_valid;
                end
                if (gnt0 || gnt1) state_nxt = ACCESS;
            end
            ACCESS: if (cnt == CNT_LAST) state_nxt = TURN;
            TURN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            write_en   <= WE_IDLE;
            address    <= '0;
            data_in    <= '0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
            last       <= 1'b1;
            cnt        <= '0;
            port       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        port     <= gnt1;
                        last     <= gnt1;
                        cnt      <= '0;
                        write_en <= (gnt1 ? req1_we : req0_we) ? WE_WR : WE_RD;
                        address  <= gnt1 ? req1_addr : req0_addr;
                        data_in  <= gnt1 ? req1_wdata : req0_wdata;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        write_en <= WE_IDLE;
                        if (write_en == WE_RD) begin
                            if (port) req1_rdata <= data_out;
                            else      req0_rdata <= data_out;
                        end
                        if (port) req1_done <= 1'b1;
                        else      req0_done <= 1'b1;
                    end
                end
                TURN: begin
                    req0_done <= 1'b0;
                    req1_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sram_access_sched.md
# sram_access_sched

- Two-port arbiter and sequencer in front of the `data_ram` SRAM controller.
- Lets the pixel loader (port 0) and the down-sampler engine (port 1) share the single external 16-bit SRAM.
- Serialises their requests with round-robin priority.
- Drives the controller's `write_en` code, address and write data for a fixed number of access cycles.
- Returns read data and a completion pulse to the winning requester.

## Interface
Parameters:
- `ADDR_W`, 20, SRAM word address width.
- `DATA_W`, 16, SRAM data width.
- `ACC_CYCLES`, 2, cycles an access code is held on `write_en`; legal range 1..15.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req0_valid` in 1: port 0 request pending.
- `req0_we` in 1: port 0 write (1) or read (0).
- `req0_addr` in ADDR_W: port 0 address.
- `req0_wdata` in DATA_W: port 0 write data.
- `req0_ready` out 1: port 0 request accepted this cycle.
- `req0_done` out 1: one-cycle pulse, port 0 access finished.
- `req0_rdata` out DATA_W: port 0 read data, valid while `req0_done`=1 after a read.
- `req1_valid`, `req1_we`, `req1_addr`, `req1_wdata`, `req1_ready`, `req1_done`, `req1_rdata`: same as port 0, for port 1.
- `write_en` out 2: controller command; 2'b11 write, 2'b00 read, 2'b01 idle.
- `address` out ADDR_W: address to the controller.
- `data_in` out DATA_W: write data to the controller.
- `data_out` in DATA_W: read data from the controller.

## Operation
- FSM states: IDLE, ACCESS, TURN.
- **IDLE**
  - If no `reqN_valid` is high, stay in IDLE.
  - If exactly one `reqN_valid` is high, grant that port.
  - If both are high, grant the port not granted last; priority pointer `last` resets to 1, so port 0 wins the first tie.
  - Grant: `reqN_ready`=1 combinationally in that cycle.
  - On the clock edge: latch `we`, address and wdata into the output registers; `write_en` <= 2'b11 or 2'b00; `last` <= N; counter <= 0; go to ACCESS.
- **ACCESS**
  - `write_en`, `address` and `data_in` are held stable.
  - Counter increments each cycle.
  - Leave when counter == ACC_CYCLES-1. On that edge:
    - `reqN_rdata` <= `data_out` (reads only; a write leaves `reqN_rdata` unchanged);
    - `write_en` <= 2'b01;
    - `reqN_done` <= 1;
    - go to TURN.
- **TURN**
  - One bus-turnaround cycle.
  - `write_en`=2'b01 and `reqN_done`=1.
  - Next edge: `done` <= 0; go to IDLE.
  - `ready` is never asserted in TURN.
- Requester rule: hold `valid`, `we`, `addr` and `wdata` stable until `ready`; drop or change them only after `ready`.
- The scheduler never asserts `ready` on both ports in one cycle.
- The scheduler never asserts `ready` outside IDLE.
- `address` and `data_in` keep their last values while idle. They are don't-care to the SRAM because `write_en`=2'b01.
- `reqN_rdata` holds its value until the next read completes on that port.

## Timing
- All outputs except `reqN_ready` are registered.
- Reset values:
  - state IDLE;
  - `write_en` 2'b01;
  - `address` 0, `data_in` 0;
  - `req0_done`/`req1_done` 0;
  - `req0_rdata`/`req1_rdata` 0;
  - `last` 1;
  - counter 0.
- Accept in cycle T:
  - `write_en` active in cycles T+1 .. T+ACC_CYCLES;
  - `done` high in cycle T+ACC_CYCLES+1 (TURN);
  - next accept no earlier than T+ACC_CYCLES+2.
- Peak throughput: one access per ACC_CYCLES+2 cycles.
- Read data is sampled at the end of the last ACCESS cycle.
- Reset asserted mid-access:
  - `write_en` returns to 2'b01 immediately (asynchronously);
  - no `done` is produced;
  - the pending transfer is lost and the requester must reissue it.
- A request that drops `valid` before `ready` is not granted. It is the requester's violation, but the FSM stays consistent.

## Test plan
- **Single write.** Port 0 writes addr 0x00010, data 0xA5A5, ACC_CYCLES=2.
  - `ready` at T;
  - `write_en`=2'b11 with `address`=0x00010 and `data_in`=0xA5A5 in T+1..T+2;
  - `req0_done` at T+3;
  - `write_en`=2'b01 at T+3.
- **Single read.** Port 1 reads 0x00010; SRAM model returns 0xA5A5.
  - `write_en`=2'b00 in T+1..T+2;
  - `req1_done`=1 with `req1_rdata`=0xA5A5 at T+3.
- **Tie after reset.** Both ports request from reset.
  - Port 0 is granted first, then port 1;
  - alternation continues, giving grants 0,1,0,1 over 4 accesses with both valid held high;
  - grants are 4 cycles apart.
- **Starvation check.** Port 0 requests continuously while port 1 raises `valid` once.
  - Port 1 is granted at the next IDLE after port 0's current access, within 4 cycles.
- **Async reset mid-access.** Assert `rst_n`=0 during the second ACCESS cycle.
  - `write_en`=2'b01 and both `done`=0 immediately;
  - after release, the first tie goes to port 0.
- **ACC_CYCLES=1 back-to-back.** Port 0 issues 3 writes.
  - Grants are 3 cycles apart;
  - each `write_en`=2'b11 pulse lasts exactly 1 cycle.
